// File: rtl/uart_tx_framer_pkg.sv
// UartGlobalPkg: shared UART types, widths and small legalisation helpers
// used by the transmit framer and its baud tick generator.
package UartGlobalPkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic {
    EVEN_PARITY = 1'b0,
    ODD_PARITY  = 1'b1
  } parityTypeEnum;

  typedef enum logic [1:0] {
    ONE_BIT = 2'd1,
    TWO_BIT = 2'd2
  } stopBitEnum;

  typedef enum logic [4:0] {
    OVERSAMPLING_13 = 5'd13,
    OVERSAMPLING_16 = 5'd16
  } overSamplingEnum;

  typedef enum logic [3:0] {
    FIVE_BITS  = 4'd5,
    SIX_BITS   = 4'd6,
    SEVEN_BITS = 4'd7,
    EIGHT_BITS = 4'd8
  } dataTypeEnum;

  typedef enum logic [3:0] {
    RESET,
    IDLE,
    STARTBIT,
    BIT0,
    BIT1,
    BIT2,
    BIT3,
    BIT4,
    BIT5,
    BIT6,
    BIT7,
    PARITYBIT,
    STOPBIT,
    INVALIDSTOPBIT
  } UartTransmitterStateEnum;

  // Data widths outside 5..8 fall back to a full byte.
  function automatic logic [3:0] legalDataBits(input logic [3:0] dataType);
    return ((dataType < 4'd5) || (dataType > 4'd8)) ? 4'd8 : dataType;
  endfunction

  // Only 13x is an alternative; anything else runs at 16x.
  function automatic logic [4:0] legalOverSampling(input logic [4:0] overSampling);
    return (overSampling == 5'd13) ? 5'd13 : 5'd16;
  endfunction

  // A divider of zero behaves like a divider of one.
  function automatic logic [15:0] legalClkDiv(input logic [15:0] clkDiv);
    return (clkDiv == 16'd0) ? 16'd1 : clkDiv;
  endfunction

endpackage

// File: rtl/uart_tx_framer_baud_tick_gen.sv
// uart_baud_tick_gen: emits one oversample tick every max(clkDiv,1) clk
// cycles. clear restarts the count so each bit period starts aligned.
module uart_baud_tick_gen
  import UartGlobalPkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] clkDiv,
  output logic        tick
);

  logic [15:0] count;
  logic [15:0] divEff;

  assign divEff = legalClkDiv(clkDiv);
  assign tick   = (count == (divEff - 16'd1));

  // Free-running divider, restarted on clear and wrapped on each tick.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (tick) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one byte per handshake into a UART frame
// (start, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits).
// Optional feature macro: UART_TX_ERR_INJ_EN adds parity and framing
// error injection inputs captured with each byte.
//
// Handshake: a byte is taken on any rising edge where txValid && txReady.
// txReady is high only in IDLE; txValid may drop at any time after the
// handshake without affecting the frame in flight.
module uart_tx_framer
  import UartGlobalPkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   txData,
  input  logic                    txValid,
  output logic                    txReady,
  input  logic [3:0]              dataType,
  input  logic                    parityEnable,
  input  logic                    parityType,
  input  logic [1:0]              stopBits,
  input  logic [4:0]              overSampling,
  input  logic [15:0]             clkDiv,
`ifdef UART_TX_ERR_INJ_EN
  input  logic                    injectParityError,
  input  logic                    injectFramingError,
`endif
  output logic                    tx,
  output logic                    busy,
  output UartTransmitterStateEnum state
);

  // Shadow copies of the frame configuration, frozen at the handshake.
  logic [DATA_WIDTH-1:0] dataReg;
  logic [3:0]            dataBitsReg;
  logic                  parityEnReg;
  logic                  parityTypeReg;
  logic [1:0]            stopBitsReg;
  logic [4:0]            ovsReg;
  logic [15:0]           clkDivReg;
`ifdef UART_TX_ERR_INJ_EN
  logic                  injParityReg;
  logic                  injFramingReg;
`endif

  logic                  stopPhase;
  logic [4:0]            ovsCnt;
  logic                  tick;
  logic                  bitDone;
  logic                  clearCounters;
  logic [2:0]            dataIdx;
  logic [2:0]            nextIdx;
  logic                  isLastData;
  logic [DATA_WIDTH-1:0] dataMask;
  logic                  parityBit;
  logic                  twoStop;
  UartTransmitterStateEnum stopState;
  logic                  stopLevel;

  assign txReady = (state == IDLE);
  assign busy    = (state != IDLE) && (state != RESET);

  // A bit period ends on the tick that completes the last oversample.
  assign bitDone       = busy && tick && (ovsCnt == (ovsReg - 5'd1));
  assign clearCounters = bitDone || !busy;

  assign dataIdx    = 3'(state - BIT0);
  assign nextIdx    = dataIdx + 3'd1;
  assign isLastData = ({1'b0, dataIdx} == (dataBitsReg - 4'd1));
  assign dataMask   = {DATA_WIDTH{1'b1}} >> (4'd8 - dataBitsReg);
  assign twoStop    = (stopBitsReg == TWO_BIT);

`ifdef UART_TX_ERR_INJ_EN
  assign parityBit = (^(dataReg & dataMask)) ^ parityTypeReg ^ injParityReg;
  assign stopState = injFramingReg ? INVALIDSTOPBIT : STOPBIT;
  assign stopLevel = !injFramingReg;
`else
  assign parityBit = (^(dataReg & dataMask)) ^ parityTypeReg;
  assign stopState = STOPBIT;
  assign stopLevel = 1'b1;
`endif

  uart_baud_tick_gen u_tickGen (
    .clk    (clk),
    .reset  (reset),
    .clear  (clearCounters),
    .clkDiv (clkDivReg),
    .tick   (tick)
  );

  // Oversample counter: counts ticks within the current bit period.
  always_ff @(posedge clk) begin
    if (reset || clearCounters) begin
      ovsCnt <= 5'd0;
    end else if (tick) begin
      ovsCnt <= ovsCnt + 5'd1;
    end
  end

  // Frame FSM: sequences the bit states and registers the serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RESET;
      tx            <= 1'b1;
      stopPhase     <= 1'b0;
      dataReg       <= '0;
      dataBitsReg   <= 4'd0;
      parityEnReg   <= 1'b0;
      parityTypeReg <= 1'b0;
      stopBitsReg   <= 2'd0;
      ovsReg        <= 5'd0;
      clkDivReg     <= 16'd0;
`ifdef UART_TX_ERR_INJ_EN
      injParityReg  <= 1'b0;
      injFramingReg <= 1'b0;
`endif
    end else begin
      case (state)
        RESET: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
        IDLE: begin
          tx <= 1'b1;
          if (txValid) begin
            dataReg       <= txData;
            dataBitsReg   <= legalDataBits(dataType);
            parityEnReg   <= parityEnable;
            parityTypeReg <= parityType;
            stopBitsReg   <= stopBits;
            ovsReg        <= legalOverSampling(overSampling);
            clkDivReg     <= clkDiv;
`ifdef UART_TX_ERR_INJ_EN
            injParityReg  <= injectParityError;
            injFramingReg <= injectFramingError;
`endif
            stopPhase     <= 1'b0;
            state         <= STARTBIT;
            tx            <= 1'b0;
          end
        end
        STARTBIT: begin
          if (bitDone) begin
            state <= BIT0;
            tx    <= dataReg[0];
          end
        end
        BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
          if (bitDone) begin
            if (!isLastData) begin
              state <= UartTransmitterStateEnum'(state + 4'd1);
              tx    <= dataReg[nextIdx];
            end else if (parityEnReg) begin
              state <= PARITYBIT;
              tx    <= parityBit;
            end else begin
              state <= stopState;
              tx    <= stopLevel;
            end
          end
        end
        PARITYBIT: begin
          if (bitDone) begin
            state <= stopState;
            tx    <= stopLevel;
          end
        end
`ifdef UART_TX_ERR_INJ_EN
        STOPBIT, INVALIDSTOPBIT: begin
`else
        STOPBIT: begin
`endif
          if (bitDone) begin
            if (twoStop && !stopPhase) begin
              stopPhase <= 1'b1;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
